work_loader_master: RTL and testbench

WORK_LOADER_MASTER -- requirements
Module: work_loader_master

---
 rtl/work_loader_pkg.sv | 35 +++
 rtl/work_word_buf.sv | 53 +++++
 rtl/work_loader_master.sv | 159 +++++++++++++++
 tb/tb_work_loader_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/work_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : work_loader_pkg
// Description : Shared state encoding and width helpers for work_loader_master.
// Revision    : 1.0 - initial release
// ============================================================================
package work_loader_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WRITE   = 3'd1;
    localparam logic [2:0] c_ST_RD_CMD  = 3'd2;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_WRITE   = c_ST_WRITE,
        ST_RD_CMD  = c_ST_RD_CMD,
        ST_RD_WAIT = c_ST_RD_WAIT,
        ST_DONE    = c_ST_DONE
    } state_t;

    // Byte lanes per data word; byteenable is DATA_W / c_BYTE_BITS bits wide.
    localparam int c_BYTE_BITS = 8;

    function automatic int be_width(input int data_w);
        return data_w / c_BYTE_BITS;
    endfunction

    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/work_word_buf.sv
`default_nettype none
// ============================================================================
// Module      : work_word_buf
// Description : NUM_WORDS x DATA_W job buffer, one sync write port, one async
//               read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module work_word_buf #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic w_wr_ok;
    logic w_rd_ok;

    // Out-of-range indices only exist when NUM_WORDS is not a power of two.
    assign w_wr_ok = (32'(wr_idx) < 32'(NUM_WORDS));
    assign w_rd_ok = (32'(rd_idx) < 32'(NUM_WORDS));

    generate
        if (NUM_WORDS == 1) begin : g_single
            logic [DATA_W-1:0] r_word;

            always_ff @(posedge clk) begin
                if (we && w_wr_ok) begin
                    r_word <= wr_data;
                end
            end

            assign rd_data = w_rd_ok ? r_word : '0;
        end else begin : g_array
            logic [DATA_W-1:0] r_mem [NUM_WORDS];

            always_ff @(posedge clk) begin
                if (we && w_wr_ok) begin
                    r_mem[wr_idx] <= wr_data;
                end
            end

            assign rd_data = w_rd_ok ? r_mem[rd_idx] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/work_loader_master.sv
`default_nettype none
// ============================================================================
// Module      : work_loader_master
// Description : Avalon-MM master that writes a buffered job of NUM_WORDS words
//               to consecutive addresses; optional readback verify is built in
//               when WORK_LOADER_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module work_loader_master
    import work_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 8,
    parameter int BASE_ADDR = 0,
    parameter int STRIDE    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            buf_we,
    input  logic [idx_width(NUM_WORDS)-1:0] buf_idx,
    input  logic [DATA_W-1:0]               buf_wdata,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            verify_err,
    output logic [ADDR_W-1:0]               avm_address,
    output logic                            avm_write,
    output logic                            avm_read,
    output logic [DATA_W-1:0]               avm_writedata,
    output logic [be_width(DATA_W)-1:0]     avm_byteenable,
    input  logic                            avm_waitrequest,
    input  logic [DATA_W-1:0]               avm_readdata,
    input  logic                            avm_readdatavalid
);

    localparam int               c_IDX_W = idx_width(NUM_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_WORDS - 1);

`ifdef WORK_LOADER_VERIFY_EN
    localparam state_t c_POST_WRITE = ST_RD_CMD;
`else
    localparam state_t c_POST_WRITE = ST_DONE;
`endif

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   w_buf_rdata;
    logic                w_buf_we;
    logic                w_last;
    logic                w_in_write;
    logic                w_in_read;
    logic [ADDR_W-1:0]   w_word_addr;

    // Buffer only accepts host writes while no job is running.
    assign w_buf_we = buf_we && (r_state == ST_IDLE);

    work_word_buf #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (c_IDX_W)
    ) u_word_buf (
        .clk     (clk),
        .we      (w_buf_we),
        .wr_idx  (buf_idx),
        .wr_data (buf_wdata),
        .rd_idx  (r_cnt),
        .rd_data (w_buf_rdata)
    );

    assign w_last      = (r_cnt == c_LAST);
    assign w_word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_cnt) * ADDR_W'(STRIDE);
    assign w_in_write  = (r_state == ST_WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= c_POST_WRITE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef WORK_LOADER_VERIFY_EN
                ST_RD_CMD: begin
                    if (!avm_waitrequest) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= ST_RD_CMD;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WORK_LOADER_VERIFY_EN
    logic r_verify_err;

    assign w_in_read = (r_state == ST_RD_CMD);

    // Sticky across the whole job; only a new launch clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_verify_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_verify_err <= 1'b0;
        end else if ((r_state == ST_RD_WAIT) && avm_readdatavalid &&
                     (avm_readdata != w_buf_rdata)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
`else
    logic w_unused_resp;

    assign w_in_read     = 1'b0;
    assign verify_err    = 1'b0;
    assign w_unused_resp = ^{avm_readdata, avm_readdatavalid};
`endif

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign avm_write      = w_in_write;
    assign avm_read       = w_in_read;
    assign avm_address    = (w_in_write || w_in_read) ? w_word_addr : '0;
    assign avm_writedata  = w_in_write ? w_buf_rdata : '0;
    assign avm_byteenable = (w_in_write || w_in_read) ? '1 : '0;

endmodule
`default_nettype wire

// File: tb/tb_work_loader_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_work_loader_master
// Description : Self-checking bench: cycle table for the default build plus
//               hand-written waitrequest and readback-verify sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_work_loader_master;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 8;
    localparam int NUM_WORDS = 8;
    localparam int BASE_ADDR = 0;
    localparam int STRIDE    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        buf_we = 1'b0;
    logic [2:0]  buf_idx = '0;
    logic [31:0] buf_wdata = '0;
    logic        start = 1'b0;
    logic        busy, done, verify_err, avm_write, avm_read;
    logic [7:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    work_loader_master #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .STRIDE    (STRIDE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .buf_we            (buf_we),
        .buf_idx           (buf_idx),
        .buf_wdata         (buf_wdata),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .verify_err        (verify_err),
        .avm_address       (avm_address),
        .avm_write         (avm_write),
        .avm_read          (avm_read),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  idx;
        logic [31:0] wd;
        logic        st;
        logic        wreq;
        logic        chk;
        logic        e_busy;
        logic        e_done;
        logic        e_wr;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic push(input logic rst, input logic we, input logic [2:0] idx,
                        input logic [31:0] wd, input logic st, input logic wreq,
                        input logic chk, input logic e_busy, input logic e_done,
                        input logic e_wr, input logic [7:0] e_addr,
                        input logic [31:0] e_data);
        vec_t v;
        v.rst = rst; v.we = we; v.idx = idx; v.wd = wd; v.st = st; v.wreq = wreq;
        v.chk = chk; v.e_busy = e_busy; v.e_done = e_done; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_data = e_data;
        vq.push_back(v);
    endtask

    task automatic add_idle(input logic rst, input logic we, input logic [2:0] idx,
                            input logic [31:0] wd, input logic st, input logic chk);
        push(rst, we, idx, wd, st, 1'b0, chk, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // Expected write of word k, whose buffer content is k.
    task automatic add_word(input int k, input logic rst, input logic st,
                            input logic we, input logic [2:0] idx,
                            input logic [31:0] wd, input logic wreq);
        push(rst, we, idx, wd, st, wreq, 1'b1, 1'b1, 1'b0, 1'b1,
             8'(BASE_ADDR + k * STRIDE), 32'(k));
    endtask

    task automatic add_done();
        push(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [3:0] e_be;
        e_be = v.e_wr ? 4'hF : 4'h0;
        n_vec++;
        if (busy !== v.e_busy || done !== v.e_done || avm_write !== v.e_wr ||
            avm_read !== 1'b0 || avm_address !== v.e_addr ||
            avm_writedata !== v.e_data || avm_byteenable !== e_be ||
            verify_err !== 1'b0) begin
            n_err++;
            $display("FAIL vec%0d: got busy=%b done=%b wr=%b rd=%b addr=%h data=%h be=%h verr=%b, want busy=%b done=%b wr=%b rd=0 addr=%h data=%h be=%h verr=0",
                     i, busy, done, avm_write, avm_read, avm_address, avm_writedata,
                     avm_byteenable, verify_err, v.e_busy, v.e_done, v.e_wr,
                     v.e_addr, v.e_data, e_be);
        end
    endtask

    task automatic expect_eq(input string name, input logic [31:0] got,
                             input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic load_buf(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < NUM_WORDS; k++) begin
            @(negedge clk);
            buf_we    = 1'b1;
            buf_idx   = 3'(k);
            buf_wdata = base + 32'(k) * step;
        end
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen_done;
        int          nw;
        int          nr;
        logic        pend;
        logic [31:0] pend_data;
        logic [31:0] smem [8];

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

`ifndef WORK_LOADER_VERIFY_EN
        // Reset check, buffer load, plain job with start/buf_we noise.
        add_idle(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < NUM_WORDS; k++) add_idle(1'b0, 1'b1, 3'(k), 32'(k), 1'b0, 1'b1);
        add_idle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
        add_word(0, 1'b0, 1'b1, 1'b1, 3'd0, 32'hFF, 1'b0);
        for (int k = 1; k < NUM_WORDS; k++) add_word(k, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        add_done();
        // Second job: word 2 stalled three cycles by waitrequest.
        add_idle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
        add_word(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        add_word(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        for (int w = 0; w < 3; w++) add_word(2, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
        for (int k = 2; k < NUM_WORDS; k++) add_word(k, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        add_done();
        // Third job aborted by reset on word 5, then a clean restart.
        add_idle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) add_word(k, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        add_word(5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        add_idle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < NUM_WORDS; k++) add_word(k, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        add_done();
        add_idle(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset           = vq[i].rst;
            buf_we          = vq[i].we;
            buf_idx         = vq[i].idx;
            buf_wdata       = vq[i].wd;
            start           = vq[i].st;
            avm_waitrequest = vq[i].wreq;
            #1;
            if (vq[i].chk) check_vec(i, vq[i]);
        end
        @(negedge clk);
        reset = 1'b0; buf_we = 1'b0; start = 1'b0; avm_waitrequest = 1'b0;

        // Random waitrequest job: order, data and completion must survive stalls.
        load_buf(32'hC0DE_0000, 32'h0000_0111);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            avm_waitrequest = ($urandom_range(0, 2) == 0);
            #1;
            if (avm_read) expect_eq("rnd_no_read", 32'(avm_read), 32'h0);
            if (avm_write && !avm_waitrequest) begin
                expect_eq("rnd_addr", 32'(avm_address), 32'(BASE_ADDR + nw * STRIDE));
                expect_eq("rnd_data", avm_writedata, 32'hC0DE_0000 + 32'(nw) * 32'h111);
                nw++;
            end
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        expect_eq("rnd_done_seen", 32'(seen_done), 32'h1);
        expect_eq("rnd_write_count", 32'(nw), 32'(NUM_WORDS));
        #1;
        expect_eq("rnd_idle_after", 32'(busy), 32'h0);
`else
        // Readback verify: slave corrupts word 3 on read.
        load_buf(32'h0, 32'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0; nr = 0; pend = 1'b0; pend_data = '0; seen_done = 1'b0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            avm_readdatavalid = pend;
            avm_readdata      = pend_data;
            #1;
            if (avm_write && avm_read) expect_eq("ver_rw_exclusive", 32'h1, 32'h0);
            pend = 1'b0;
            if (avm_write) begin
                smem[avm_address[4:2]] = avm_writedata;
                if (nr != 0) expect_eq("ver_write_after_read", 32'(nr), 32'h0);
                nw++;
            end
            if (avm_read) begin
                expect_eq("ver_rd_addr", 32'(avm_address), 32'(nr * STRIDE));
                pend      = 1'b1;
                pend_data = (avm_address == 8'h0C) ? 32'hDEAD : smem[avm_address[4:2]];
                nr++;
            end
            if (done) begin
                seen_done = 1'b1;
                expect_eq("ver_err_at_done", 32'(verify_err), 32'h1);
            end
            @(negedge clk);
        end
        avm_readdatavalid = 1'b0;
        expect_eq("ver_done_seen", 32'(seen_done), 32'h1);
        expect_eq("ver_write_count", 32'(nw), 32'(NUM_WORDS));
        expect_eq("ver_read_count", 32'(nr), 32'(NUM_WORDS));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        expect_eq("ver_err_cleared", 32'(verify_err), 32'h0);
        expect_eq("ver_restart_busy", 32'(busy), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
